bus_bridge88: RTL and testbench

- Sits between the core88 byte bus (address/bus/data/wreq/locked) and an external 16-bit asynchronous SRAM.
- Turns each byte access into a word-wide SRAM cycle with a programmable wait count.
- Keeps a one-word read buffer so that sequential byte fetches (opcode, modrm, disp, imm) in the same word complete without stalling.
- Drives the core's `locked` input; the core advances only on edges where that input is 1.

---
 rtl/bus_bridge88_if.sv | 18 +
 rtl/bus_bridge88.sv | 154 +++++++++++++++
 tb/tb_bus_bridge88.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_bridge88_if.sv
// Core88 byte-bus handshake bundle: address/write request from the core, read byte and ready back.
interface bus_bridge88_if;
    logic [19:0] core_address;
    logic [7:0]  core_wdata;
    logic        core_wreq;
    logic [7:0]  core_rdata;
    logic        core_ready;

    modport master (
        output core_address, core_wdata, core_wreq,
        input  core_rdata, core_ready
    );

    modport slave (
        input  core_address, core_wdata, core_wreq,
        output core_rdata, core_ready
    );
endinterface

// File: rtl/bus_bridge88.sv
// Core88 byte bus to 16-bit async SRAM bridge with a one-word read buffer.
// Latency: buffered read 0 stalls, miss/write WAIT+2 stalls; core stalls via core_ready=0 (pll_locked gates it).
module bus_bridge88 #(
    parameter int unsigned WAIT = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pll_locked,
    bus_bridge88_if.slave core,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_dout,
    input  logic [15:0] sram_din,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, RD, WR, WDONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] buf_q, buf_n;
    logic [18:0] tag, tag_n;
    logic        buf_valid, buf_valid_n;
    logic        wr_odd, wr_odd_n;
    logic [18:0] addr_n;
    logic [15:0] dout_n;
    logic        dq_oe_n, ce_n_n, oe_n_n, we_n_n, ub_n_n, lb_n_n;
    logic        hit;

    assign hit             = buf_valid && (tag == core.core_address[19:1]);
    assign core.core_rdata = core.core_address[0] ? buf_q[15:8] : buf_q[7:0];
    assign core.core_ready = resetn && pll_locked &&
                             (((state == IDLE) && !core.core_wreq && hit) || (state == WDONE));

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        buf_n       = buf_q;
        tag_n       = tag;
        buf_valid_n = buf_valid;
        wr_odd_n    = wr_odd;
        addr_n      = sram_addr;
        dout_n      = sram_dout;
        dq_oe_n     = sram_dq_oe;
        ce_n_n      = sram_ce_n;
        oe_n_n      = sram_oe_n;
        we_n_n      = sram_we_n;
        ub_n_n      = sram_ub_n;
        lb_n_n      = sram_lb_n;

        case (state)
            IDLE: begin
                if (pll_locked) begin
                    if (core.core_wreq) begin
                        addr_n   = core.core_address[19:1];
                        dout_n   = {core.core_wdata, core.core_wdata};
                        wr_odd_n = core.core_address[0];
                        dq_oe_n  = 1'b1;
                        ce_n_n   = 1'b0;
                        we_n_n   = 1'b0;
                        ub_n_n   = ~core.core_address[0];
                        lb_n_n   = core.core_address[0];
                        cnt_n    = WAIT_CNT;
                        state_n  = WR;
                    end else if (!hit) begin
                        addr_n  = core.core_address[19:1];
                        ce_n_n  = 1'b0;
                        oe_n_n  = 1'b0;
                        ub_n_n  = 1'b0;
                        lb_n_n  = 1'b0;
                        cnt_n   = WAIT_CNT;
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    buf_n       = sram_din;
                    tag_n       = sram_addr;
                    buf_valid_n = 1'b1;
                    ce_n_n      = 1'b1;
                    oe_n_n      = 1'b1;
                    ub_n_n      = 1'b1;
                    lb_n_n      = 1'b1;
                    state_n     = IDLE;
                end
            end
            WR: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    // dq_oe is left asserted so data is held one cycle past we_n rising
                    we_n_n  = 1'b1;
                    ce_n_n  = 1'b1;
                    ub_n_n  = 1'b1;
                    lb_n_n  = 1'b1;
                    state_n = WDONE;
                end
            end
            WDONE: begin
                dq_oe_n = 1'b0;
                if (buf_valid && (tag == sram_addr)) begin
                    if (wr_odd) buf_n[15:8] = sram_dout[7:0];
                    else        buf_n[7:0]  = sram_dout[7:0];
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            buf_q      <= 16'd0;
            tag        <= 19'd0;
            buf_valid  <= 1'b0;
            wr_odd     <= 1'b0;
            sram_addr  <= 19'd0;
            sram_dout  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            buf_q      <= buf_n;
            tag        <= tag_n;
            buf_valid  <= buf_valid_n;
            wr_odd     <= wr_odd_n;
            sram_addr  <= addr_n;
            sram_dout  <= dout_n;
            sram_dq_oe <= dq_oe_n;
            sram_ce_n  <= ce_n_n;
            sram_oe_n  <= oe_n_n;
            sram_we_n  <= we_n_n;
            sram_ub_n  <= ub_n_n;
            sram_lb_n  <= lb_n_n;
        end
    end

endmodule

// File: tb/tb_bus_bridge88.sv
// Bench for bus_bridge88: directed vector table, hand-written corner sequences, random traffic vs a byte-level model.
module tb_bus_bridge88;

    localparam int WAIT  = 2;
    localparam int STALL = WAIT + 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pll_locked;
    logic [18:0] sram_addr;
    logic [15:0] sram_dout;
    logic [15:0] sram_din;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    bus_bridge88_if cif();

    bus_bridge88 #(.WAIT(WAIT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .core       (cif.slave),
        .sram_addr  (sram_addr),
        .sram_dout  (sram_dout),
        .sram_din   (sram_din),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM device model ----------------
    logic [15:0] mem [bit [18:0]];

    function automatic logic [15:0] default_word(input logic [18:0] w);
        return {w[7:0] ^ 8'hC3, w[15:8] + 8'h11};
    endfunction

    function automatic logic [15:0] mem_word(input logic [18:0] w);
        return mem.exists(w) ? mem[w] : default_word(w);
    endfunction

    initial sram_din = 16'hDEAD;
    always @(negedge clock) begin
        logic [15:0] w;
        if (!sram_ce_n && !sram_we_n) begin
            w = mem_word(sram_addr);
            if (!sram_lb_n) w[7:0]  = sram_dout[7:0];
            if (!sram_ub_n) w[15:8] = sram_dout[15:8];
            mem[sram_addr] = w;
        end
        sram_din = (!sram_ce_n && !sram_oe_n) ? mem_word(sram_addr) : 16'hDEAD;
    end

    always @(negedge clock) begin
        total++;
        if (!sram_we_n && !sram_oe_n) begin
            bad++;
            $display("FAIL we_oe_exclusive: we_n=%0b oe_n=%0b at %0t", sram_we_n, sram_oe_n, $time);
        end
    end

    // ---------------- byte-level reference model ----------------
    logic [7:0]  ref_mem [bit [19:0]];
    logic        ref_valid = 1'b0;
    logic [18:0] ref_tag   = '0;

    function automatic logic [7:0] ref_byte(input logic [19:0] a);
        logic [15:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = default_word(a[19:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic int ref_stall(input logic [19:0] a, input logic wr);
        if (wr) return STALL;
        return (ref_valid && ref_tag == a[19:1]) ? 0 : STALL;
    endfunction

    function automatic void ref_update(input logic [19:0] a, input logic wr, input logic [7:0] d);
        if (wr) ref_mem[a] = d;
        else begin
            ref_valid = 1'b1;
            ref_tag   = a[19:1];
        end
    endfunction

    function automatic void preload(input logic [18:0] w, input logic [15:0] v);
        mem[w] = v;
        ref_mem[{w, 1'b0}] = v[7:0];
        ref_mem[{w, 1'b1}] = v[15:8];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the access is consumed.
    task automatic do_access(input logic [19:0] a, input logic wr, input logic [7:0] d,
                             input int exp_stall, input logic [7:0] exp_rd,
                             input int exp_oe, input int exp_we);
        int stalls = 0, oe_cyc = 0, we_cyc = 0;
        bit done = 0;
        cif.core_address = a;
        cif.core_wreq    = wr;
        cif.core_wdata   = d;
        while (!done) begin
            @(negedge clock);
            if (!sram_oe_n) oe_cyc++;
            if (!sram_we_n) begin
                we_cyc++;
                chk("we_lanes", {sram_ub_n, sram_lb_n}, {~a[0], a[0]});
                chk("we_dout", sram_dout, {d, d});
                chk("we_addr", sram_addr, a[19:1]);
            end
            if (cif.core_ready) begin
                done = 1;
                chk("stall", stalls, exp_stall);
                if (!wr) chk("rdata", cif.core_rdata, exp_rd);
                else     chk("wdone_hold", {sram_dq_oe, sram_we_n}, 2'b11);
            end else if (++stalls > 40) begin
                chk("ready_timeout", stalls, exp_stall);
                done = 1;
            end
        end
        chk("oe_cycles", oe_cyc, exp_oe);
        chk("we_cycles", we_cyc, exp_we);
        @(posedge clock); #1;
        cif.core_wreq = 1'b0;
        if (wr) chk("dq_oe_drop", sram_dq_oe, 1'b0);
        ref_update(a, wr, d);
    endtask

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [7:0]  wd;
        int          stall;
        logic [7:0]  rd;
        int          oe;
        int          we;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{20'hFFFF0, 1'b0, 8'h00, STALL, 8'h90, WAIT + 1, 0};
        tbl[1] = '{20'hFFFF1, 1'b0, 8'h00, 0,     8'hEA, 0,        0};
        tbl[2] = '{20'h00100, 1'b0, 8'h00, STALL, 8'h34, WAIT + 1, 0};
        tbl[3] = '{20'h00101, 1'b1, 8'hA5, STALL, 8'h00, 0,        WAIT + 1};
        tbl[4] = '{20'h00101, 1'b0, 8'h00, 0,     8'hA5, 0,        0};
        tbl[5] = '{20'h00100, 1'b0, 8'h00, 0,     8'h34, 0,        0};

        preload(19'h7FFF8, 16'hEA90);
        preload(19'h00080, 16'h1234);

        resetn = 1'b0;
        pll_locked = 1'b1;
        cif.core_address = 20'hFFFF0;
        cif.core_wdata   = 8'h00;
        cif.core_wreq    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_ready", cif.core_ready, 1'b0);
        chk("rst_addr", sram_addr, 19'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++)
            do_access(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].stall, tbl[i].rd, tbl[i].oe, tbl[i].we);

        // pll_locked drops during a read miss: SRAM cycle completes, ready held off
        cif.core_address = 20'h20000;
        @(negedge clock);
        chk("pll_miss_ready", cif.core_ready, 1'b0);
        @(posedge clock); #1;
        pll_locked = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk("pll_low_ready", cif.core_ready, 1'b0);
        end
        chk("pll_low_strobes", {sram_ce_n, sram_oe_n}, 2'b11);
        @(posedge clock); #1;
        pll_locked = 1'b1;
        @(negedge clock);
        chk("pll_back_ready", cif.core_ready, 1'b1);
        chk("pll_back_rdata", cif.core_rdata, ref_byte(20'h20000));
        @(posedge clock); #1;
        ref_update(20'h20000, 1'b0, 8'h00);

        // reset in the middle of a write aborts it and drops the buffer
        cif.core_address = 20'h00200;
        cif.core_wdata   = 8'h77;
        cif.core_wreq    = 1'b1;
        @(posedge clock); #1;
        cif.core_wreq = 1'b0;
        @(negedge clock);
        chk("wr_active_we", sram_we_n, 1'b0);
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_dq_oe", sram_dq_oe, 1'b0);
        chk("abort_ready", cif.core_ready, 1'b0);
        resetn = 1'b1;
        ref_mem[20'h00200] = 8'h77;
        ref_valid = 1'b0;
        do_access(20'h00101, 1'b0, 8'h00, STALL, 8'hA5, WAIT + 1, 0);

        // random traffic over a small window so buffer hits and write-through occur
        for (int i = 0; i < 150; i++) begin
            logic [19:0] a;
            logic        wr;
            logic [7:0]  d;
            int          st;
            a  = 20'h80000 + 20'($urandom_range(0, 11));
            wr = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            st = ref_stall(a, wr);
            do_access(a, wr, d, st, ref_byte(a),
                      (!wr && st != 0) ? WAIT + 1 : 0, wr ? WAIT + 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
